// File: rtl/mips_inst_encoder.sv
// MIPS instruction encoder: field-level requests are encoded into 32-bit words, buffered in a FIFO
// and emitted with a word address. Optional macro ENC_ILLEGAL_CHK_EN drops reserved opcodes 6'h18-6'h1F (except SPECIAL2).
package mips_pkg;
   localparam logic [5:0] Op_Type_R   = 6'h00;
   localparam logic [5:0] Op_Type_R2  = 6'h1C;
   localparam logic [5:0] Op_Type_CP0 = 6'h10;
   localparam logic [5:0] Op_J        = 6'h02;
   localparam logic [5:0] Op_Jal      = 6'h03;
endpackage

module mips_inst_encoder #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [29:0] BASE_ADDR  = 30'h0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        In_Valid,
   output logic                        In_Ready,
   input  logic [5:0]                  OpCode,
   input  logic [4:0]                  Rs,
   input  logic [4:0]                  Rt,
   input  logic [4:0]                  Rd,
   input  logic [4:0]                  Shamt,
   input  logic [5:0]                  Funct,
   input  logic [2:0]                  Cp0_Sel,
   input  logic [15:0]                 Immediate,
   input  logic [25:0]                 JumpAddress,
   output logic                        Out_Valid,
   input  logic                        Out_Ready,
   output logic [31:0]                 InstMem_Out,
   output logic [29:0]                 InstMem_Addr,
   input  logic                        Addr_Load,
   input  logic [29:0]                 Addr_Value,
   output logic [$clog2(FIFO_DEPTH):0] Inst_Count,
   output logic                        Enc_Err
);
   import mips_pkg::*;

   localparam int          PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [29:0]   addr_q, addr_d;
   logic          push, pop, illegal, store;

   function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                          input logic [2:0] sel, input logic [15:0] imm, input logic [25:0] ja);
      logic [31:0] w;
      if (op == Op_Type_CP0)
         w = {op, rs, rt, rd, 8'b0, sel};
      else if (op == Op_Type_R || op == Op_Type_R2)
         w = {op, rs, rt, rd, sh, fn};
      else if (op == Op_J || op == Op_Jal)
         w = {op, ja};
      else
         w = {op, rs, rt, imm};
      return w;
   endfunction

   assign In_Ready     = (count_q < DEPTH_C);
   assign Out_Valid    = (count_q != '0);
   assign push         = In_Valid & In_Ready;
   assign pop          = Out_Valid & Out_Ready;
   assign store        = push & ~illegal & ~reset;
   assign Inst_Count   = count_q;
   assign InstMem_Addr = addr_q;
   assign InstMem_Out  = Out_Valid ? mem_q[rd_ptr_q] : 32'h0;

`ifdef ENC_ILLEGAL_CHK_EN
   logic err_q;
   assign illegal = (OpCode[5:3] == 3'b011) && (OpCode != Op_Type_R2);
   assign Enc_Err = err_q;

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= push & illegal;
   end
`else
   assign illegal = 1'b0;
   assign Enc_Err = 1'b0;
`endif

   // Address load wins over the post-pop increment.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      addr_d   = addr_q;
      if (store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (store && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!store && pop) count_d = count_q - (PW+1)'(1);
      if (Addr_Load) addr_d = Addr_Value;
      else if (pop)  addr_d = addr_q + 30'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         addr_q   <= addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= encode(OpCode, Rs, Rt, Rd, Shamt, Funct, Cp0_Sel, Immediate, JumpAddress);
   end
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Bench for mips_inst_encoder: queue-based reference model compared every cycle, directed
// literal scenarios, then randomized traffic including address loads and mid-run resets.
`timescale 1ns/1ps
module tb_mips_inst_encoder;
   localparam int          DEPTH = 4;
   localparam logic [29:0] BASE  = 30'h0;

   logic        clk, reset, In_Valid, In_Ready, Out_Valid, Out_Ready, Addr_Load, Enc_Err;
   logic [5:0]  OpCode, Funct;
   logic [4:0]  Rs, Rt, Rd, Shamt;
   logic [2:0]  Cp0_Sel;
   logic [15:0] Immediate;
   logic [25:0] JumpAddress;
   logic [31:0] InstMem_Out;
   logic [29:0] InstMem_Addr, Addr_Value;
   logic [$clog2(DEPTH):0] Inst_Count;

   mips_inst_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .OpCode(OpCode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
      .Cp0_Sel(Cp0_Sel), .Immediate(Immediate), .JumpAddress(JumpAddress),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .InstMem_Out(InstMem_Out),
      .InstMem_Addr(InstMem_Addr), .Addr_Load(Addr_Load), .Addr_Value(Addr_Value),
      .Inst_Count(Inst_Count), .Enc_Err(Enc_Err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] mq[$];
   logic [29:0] m_addr = BASE;
   bit          m_err  = 1'b0;
   bit          chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit illegal_op(input logic [5:0] op);
`ifdef ENC_ILLEGAL_CHK_EN
      return (op >= 6'h18) && (op <= 6'h1F) && (op != 6'h1C);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_word(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                              input logic [2:0] sel, input logic [15:0] imm, input logic [25:0] ja);
      int unsigned w;
      w = int'(op) << 26;
      if (op == 6'h02 || op == 6'h03)
         w = w + int'(ja);
      else begin
         w = w + (int'(rs) << 21) + (int'(rt) << 16);
         if (op == 6'h10)                   w = w + (int'(rd) << 11) + int'(sel);
         else if (op == 6'h00 || op == 6'h1C) w = w + (int'(rd) << 11) + (int'(sh) << 6) + int'(fn);
         else                                 w = w + int'(imm);
      end
      return w;
   endfunction

   always @(posedge clk) begin : model
      bit m_push, m_pop;
      m_push = In_Valid && (mq.size() < DEPTH);
      m_pop  = Out_Ready && (mq.size() != 0);
      if (reset) begin
         mq.delete();
         m_addr = BASE;
         m_err  = 1'b0;
         chk_en = 1'b1;
      end else begin
         if (m_pop) void'(mq.pop_front());
         m_err = m_push && illegal_op(OpCode);
         if (m_push && !illegal_op(OpCode))
            mq.push_back(model_word(OpCode, Rs, Rt, Rd, Shamt, Funct, Cp0_Sel, Immediate, JumpAddress));
         if (Addr_Load)  m_addr = Addr_Value;
         else if (m_pop) m_addr = m_addr + 30'd1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  32'(In_Ready),     32'(mq.size() < DEPTH));
         check("out_valid", 32'(Out_Valid),    32'(mq.size() != 0));
         check("count",     32'(Inst_Count),   32'(mq.size()));
         check("addr",      32'(InstMem_Addr), 32'(m_addr));
         check("enc_err",   32'(Enc_Err),      32'(m_err));
         if (mq.size() != 0) check("word", InstMem_Out, mq[0]);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic req(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [5:0] fn, input logic [2:0] sel,
                      input logic [15:0] imm, input logic [25:0] ja);
      OpCode = op; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Funct = fn;
      Cp0_Sel = sel; Immediate = imm; JumpAddress = ja;
   endtask

   initial begin
      reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0; Addr_Load = 1'b0; Addr_Value = '0;
      req(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();
      check("rst_count", 32'(Inst_Count), 0);
      check("rst_out_valid", 32'(Out_Valid), 0);
      check("rst_in_ready", 32'(In_Ready), 1);
      check("rst_word", InstMem_Out, 32'h0);
      check("rst_addr", 32'(InstMem_Addr), 32'(BASE));
      check("rst_err", 32'(Enc_Err), 0);
      reset = 1'b0;

      // R format add
      req(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 3'd0, 16'h0, 26'h0);
      In_Valid = 1'b1; step(); In_Valid = 1'b0;
      check("r_word", InstMem_Out, 32'h00221820);
      check("r_addr", 32'(InstMem_Addr), 32'(BASE));
      check("r_valid", 32'(Out_Valid), 1);
      Out_Ready = 1'b1; step(); Out_Ready = 1'b0;
      check("r_drained", 32'(Out_Valid), 0);
      check("r_addr_inc", 32'(InstMem_Addr), 32'(BASE + 30'd1));

      // I format then JAL, pushed while the I word is popped
      req(6'h08, 5'd0, 5'd5, 5'd0, 5'd0, 6'h0, 3'd0, 16'hFFFF, 26'h0);
      In_Valid = 1'b1; step();
      check("i_word", InstMem_Out, 32'h2005FFFF);
      check("i_addr", 32'(InstMem_Addr), 32'(BASE + 30'd1));
      req(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 3'd0, 16'h0, 26'h0000040);
      Out_Ready = 1'b1; step(); In_Valid = 1'b0;
      check("j_word", InstMem_Out, 32'h0C000040);
      check("j_addr", 32'(InstMem_Addr), 32'(BASE + 30'd2));
      check("j_count", 32'(Inst_Count), 1);
      step(); Out_Ready = 1'b0;

      // fill past capacity with the sink stalled
      for (int i = 0; i < 5; i++) begin
         req(6'h0D, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 3'd0, 16'h100 + 16'(i), 26'h0);
         In_Valid = 1'b1; step();
         if (i >= 3) begin
            check("full_in_ready", 32'(In_Ready), 0);
            check("full_count", 32'(Inst_Count), 4);
         end
      end
      In_Valid = 1'b0; Out_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_word", InstMem_Out, 32'h34000100 + 32'(i));
         check("drain_addr", 32'(InstMem_Addr), 32'(BASE + 30'd3 + 30'(i)));
         step();
      end
      check("drain_empty", 32'(Out_Valid), 0);
      Out_Ready = 1'b0;

      // address wrap and load-vs-pop priority
      Addr_Load = 1'b1; Addr_Value = 30'h3FFFFFFF; step(); Addr_Load = 1'b0;
      check("load_addr", 32'(InstMem_Addr), 32'h3FFFFFFF);
      In_Valid = 1'b1; step(); step(); In_Valid = 1'b0;
      Out_Ready = 1'b1;
      check("wrap_addr0", 32'(InstMem_Addr), 32'h3FFFFFFF);
      step();
      check("wrap_addr1", 32'(InstMem_Addr), 32'h0);
      step();
      check("wrap_empty", 32'(Out_Valid), 0);
      check("wrap_addr2", 32'(InstMem_Addr), 32'h1);
      Out_Ready = 1'b0;
      In_Valid = 1'b1; step(); In_Valid = 1'b0;
      Out_Ready = 1'b1; Addr_Load = 1'b1; Addr_Value = 30'h1234; step();
      Addr_Load = 1'b0; Out_Ready = 1'b0;
      check("load_pop_addr", 32'(InstMem_Addr), 32'h1234);
      check("load_pop_empty", 32'(Out_Valid), 0);

      // reserved opcode, then reset with 3 words buffered
      In_Valid = 1'b1; step(); step();
      req(6'h18, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 3'd0, 16'hABCD, 26'h0);
      step(); In_Valid = 1'b0;
`ifdef ENC_ILLEGAL_CHK_EN
      check("ill_err", 32'(Enc_Err), 1);
      check("ill_count", 32'(Inst_Count), 2);
      step();
      check("ill_err_clear", 32'(Enc_Err), 0);
      req(6'h0D, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 3'd0, 16'h7, 26'h0);
      In_Valid = 1'b1; step(); In_Valid = 1'b0;
`else
      check("ill_err", 32'(Enc_Err), 0);
`endif
      check("pre_rst_count", 32'(Inst_Count), 3);
      reset = 1'b1; In_Valid = 1'b1; Out_Ready = 1'b1; step();
      reset = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
      check("mid_rst_count", 32'(Inst_Count), 0);
      check("mid_rst_valid", 32'(Out_Valid), 0);
      check("mid_rst_addr", 32'(InstMem_Addr), 32'(BASE));

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         logic [5:0] op;
         case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h1C;
            2: op = 6'h10;
            3: op = 6'h02;
            4: op = 6'h03;
            5: op = 6'h18 + 6'($urandom_range(0, 7));
            default: op = 6'($urandom);
         endcase
         req(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             3'($urandom), 16'($urandom), 26'($urandom));
         In_Valid   = ($urandom_range(0, 9) < 6);
         Out_Ready  = ($urandom_range(0, 9) < 5);
         Addr_Load  = ($urandom_range(0, 31) == 0);
         Addr_Value = 30'($urandom);
         reset      = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; Addr_Load = 1'b0;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
